// File: rtl/fetch_sequencer_pkg.sv
// Shared opcodes, halt codes and state encodings
// for the fetch sequencer and its next-PC logic.
package fetch_sequencer_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] HALT_LOOP_INSTR = 32'h0000_0063;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_LOOP     = 2'b01,
    CAUSE_LIMIT    = 2'b10,
    CAUSE_MISALIGN = 2'b11
  } cause_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_e;

  function automatic logic [31:0] imm_j(
    input logic [31:0] i
  );
    logic [20:0] t;
    t = {i[31], i[19:12], i[20],
         i[30:21], 1'b0};
    return {{11{t[20]}}, t};
  endfunction

  function automatic logic [31:0] imm_b(
    input logic [31:0] i
  );
    logic [12:0] t;
    t = {i[31], i[7], i[30:25],
         i[11:8], 1'b0};
    return {{19{t[12]}}, t};
  endfunction

endpackage

// File: rtl/fetch_sequencer_next_pc_gen.sv
// Combinational next-PC selection with
// self-loop and misalignment detection.
module next_pc_gen
  import fetch_sequencer_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        branch_taken,
  input  logic [31:0] jalr_target,
  output logic [31:0] next_pc,
  output logic        is_self_loop,
  output logic        misaligned
);

  logic [6:0] opcode;
  logic       is_jal;
  logic       is_jalr;
  logic       is_br_t;

  assign opcode       = instr[6:0];
  assign is_self_loop = (instr == HALT_LOOP_INSTR);
  assign is_jal       = (opcode == OP_JAL);
  assign is_jalr      = (opcode == OP_JALR);
  // The self-loop word is itself a branch, so keep the arms disjoint
  assign is_br_t      = (opcode == OP_BRANCH)
                      & branch_taken
                      & ~is_self_loop;

  always_comb begin
    next_pc = pc + 32'd4;
    unique case (1'b1)
      is_self_loop: next_pc = pc;
      is_jal:       next_pc = pc + imm_j(instr);
      is_jalr:      next_pc = jalr_target
                            & ~32'h1;
      is_br_t:      next_pc = pc + imm_b(instr);
      default:      next_pc = pc + 32'd4;
    endcase
  end

  assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter, retire counter and the
// IDLE/RUN/HALT sequencing FSM.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MAX_INSTR = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  input  logic [31:0]      instr,
  input  logic             branch_taken,
  input  logic [31:0]      jalr_target,
  output logic [31:0]      pc,
  output logic             instr_valid,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [CNT_W:0] LIMIT =
    (CNT_W+1)'(MAX_INSTR);

  state_e           state_q, state_d;
  cause_e           cause_q, cause_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W:0]   cnt_wide;
  logic             limit_hit;
  logic [31:0]      next_pc;
  logic             is_self_loop;
  logic             misaligned;

  next_pc_gen u_next_pc_gen (
    .pc           (pc_q),
    .instr        (instr),
    .branch_taken (branch_taken),
    .jalr_target  (jalr_target),
    .next_pc      (next_pc),
    .is_self_loop (is_self_loop),
    .misaligned   (misaligned)
  );

  assign cnt_wide  = {1'b0, cnt_q}
                   + (CNT_W+1)'(1);
  assign cnt_inc   = (&cnt_q) ? cnt_q
                   : cnt_wide[CNT_W-1:0];
  assign limit_hit = (MAX_INSTR != 0)
                   && (cnt_wide == LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cause_q <= CAUSE_NONE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        // Stall outranks every halt check
        if (!stall) begin
          if (is_self_loop) begin
            state_d = S_HALT;
            cause_d = CAUSE_LOOP;
          end else if (misaligned) begin
            state_d = S_HALT;
            cause_d = CAUSE_MISALIGN;
            cnt_d   = cnt_inc;
          end else begin
            pc_d  = next_pc;
            cnt_d = cnt_inc;
            if (limit_hit) begin
              state_d = S_HALT;
              cause_d = CAUSE_LIMIT;
            end
          end
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc          = pc_q;
    instr_count = cnt_q;
    halt_cause  = cause_q;
    halted      = (state_q == S_HALT);
    instr_valid = (state_q == S_RUN) & ~stall;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Owns the program counter and sequences the Instruction_Memory. Drives Address each cycle and takes back ReadData. Selects the next PC from PC+4, branch target, JAL target or JALR target. Detects end-of-program conditions (self-loop BEQ x0,x0,0, instruction limit, misaligned target), then parks the core in a sticky HALT state.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
MAX_INSTR, 0, retired-instruction limit; 0 disables the limit.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset; asynchronous, active-low.
start  in  1  pulse; leaves IDLE and begins fetching.
stall  in  1  core not ready; hold PC and suppress retire.
instr  in  32  ReadData from Instruction_Memory for current pc.
branch_taken  in  1  condition result from core ALU; meaningful only for branch opcodes.
jalr_target  in  32  rs1+imm computed by the core for JALR.
pc  out  32  Address to Instruction_Memory.
instr_valid  out  1  instr at pc retires this cycle.
halted  out  1  sequencer is in HALT.
halt_cause  out  2  00 none, 01 self-loop, 10 limit, 11 misaligned target.
instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=IDLE, halted=0, halt_cause=00, instr_count=0. instr_valid is 0 combinationally.
- States: IDLE, RUN, HALT. Encoded as 2-bit state.
- IDLE -> RUN: on start=1. pc is unchanged. The first instruction is fetched from RESET_PC in the first RUN cycle.
- RUN: instr_valid = ~stall. Address-to-data is combinational: instr corresponds to the same-cycle pc.
- RUN with stall=1: pc, instr_count and state all hold. Stall has priority over every halt detection.
- RUN with stall=0: the instruction retires, and next_pc is chosen by this priority:
  1. instr==32'h0000_0063: -> HALT, cause 01, pc holds, count NOT incremented.
  2. opcode 1101111 (JAL): pc + sext(imm_j).
  3. opcode 1100111 (JALR): jalr_target & ~32'h1.
  4. opcode 1100011 and branch_taken: pc + sext(imm_b).
  5. Otherwise: pc + 4.
- Immediate extraction:
  - imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 0}, sign-extended from 21 bits.
  - imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 0}, sign-extended from 13 bits.
- All PC arithmetic is 32-bit modulo 2^32; wrap-around is silent.
- Misaligned next_pc (next_pc[1:0]!=0): -> HALT, cause 11, pc holds at the faulting instruction, count incremented (the instruction retired).
- Limit: if MAX_INSTR!=0 and instr_count+1==MAX_INSTR on a retire, count is updated, pc advances, then -> HALT, cause 10.
- Self-loop and misaligned take precedence over limit in the same cycle.
- instr_count saturates at all-ones and never wraps.
- HALT: sticky. pc, count and cause frozen; instr_valid=0; start is ignored. Only rst exits HALT.
- start while in RUN: ignored.
- Reset asserted mid-RUN: immediate return to reset values. No partial update of any output.

Decomposition:
- Shared definitions (define.v): opcode constants OP_JAL, OP_JALR, OP_BRANCH; HALT_LOOP_INSTR=32'h0000_0063; halt_cause codes; state encodings.
- One combinational sub-module, next_pc_gen. Inputs: pc, instr, branch_taken, jalr_target. Outputs: next_pc, is_self_loop, misaligned.
- fetch_sequencer keeps the FSM, pc register and counter.

Test Plan:
- Reset/start: rst low then high, pulse start at t=30 -> pc=0, instr_valid=0 until RUN, then pc steps 0,4,8 on NOP (0x00000013) stream; instr_count=3 after 3 cycles.
- JAL: pc=0x8, instr=0x0080006F -> next pc=0x10, instr_count increments by 1.
- Branch: pc=0x10, instr=0xFE208EE3 with branch_taken=1 -> pc=0x0C; same with branch_taken=0 -> pc=0x14.
- Stall: assert stall 3 cycles at pc=0x14 -> pc stays 0x14, instr_valid=0, count unchanged; resumes at 0x18 after release.
- Self-loop: instr=0x00000063 at pc=0x20 -> halted=1, halt_cause=01, pc stays 0x20, count not incremented. A later start pulse has no effect.
- Limit/misaligned:
  - MAX_INSTR=20 with NOP stream -> halt after 20th retire, pc=0x50, cause 10.
  - JALR with jalr_target=0x102 -> next_pc=0x102, halt cause 11.
  - rst mid-RUN -> pc=RESET_PC at once.
